// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the handshaked instruction fetch controller.
// Optional misaligned-target trapping is enabled with `define MISALIGN_TRAP_EN.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_BOOT,
      S_REQ,
      S_WAIT
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

   // Clears the byte-offset bits so every fetch address lands on a word boundary
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~(PC_STEP - 32'd1);
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response and decode-buffer handshake bundle.
// The trap line only exists when MISALIGN_TRAP_EN is defined.
interface fetch_ctrl_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        branch;
   logic        zero_flag;
   logic [31:0] imm;
   logic        jump;
   logic [31:0] jump_target;
`ifdef MISALIGN_TRAP_EN
   logic        trap;
`endif

   // The fetch controller drives requests and the decode buffer
   modport master (
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata,
      input  instr_ready,
      input  branch,
      input  zero_flag,
      input  imm,
      input  jump,
      input  jump_target,
`ifdef MISALIGN_TRAP_EN
      output trap,
`endif
      output imem_req,
      output imem_addr,
      output instr_valid,
      output instr,
      output instr_pc
   );

   modport slave (
      output imem_ready,
      output imem_rvalid,
      output imem_rdata,
      output instr_ready,
      output branch,
      output zero_flag,
      output imm,
      output jump,
      output jump_target,
`ifdef MISALIGN_TRAP_EN
      input  trap,
`endif
      input  imem_req,
      input  imem_addr,
      input  instr_valid,
      input  instr,
      input  instr_pc
   );

endinterface

// File: rtl/fetch_ctrl_next_pc_sel.sv
// Resolves the redirect for the instruction decode is consuming and picks the next PC.
// With MISALIGN_TRAP_EN a misaligned taken target diverts to TRAP_VEC and raises trap.
module next_pc_sel
   import fetch_pkg::*;
#(
`ifdef MISALIGN_TRAP_EN
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`endif
) (
   input  logic        i_consume,
   input  logic        i_branch,
   input  logic        i_zero_flag,
   input  logic [31:0] i_imm,
   input  logic        i_jump,
   input  logic [31:0] i_jump_target,
   input  logic [31:0] i_instr_pc,
   input  logic [31:0] i_pc_q,
`ifdef MISALIGN_TRAP_EN
   output logic        o_trap,
`endif
   output logic        o_taken,
   output logic [31:0] o_next_pc
);

   logic [31:0] w_target;
`ifdef MISALIGN_TRAP_EN
   logic        w_misalign;
`endif

   // Decode inputs only matter in the consume cycle, so taken is gated by consume
   always_comb begin
      o_taken  = i_consume & (i_jump | (i_branch & i_zero_flag));
      w_target = i_jump ? i_jump_target : (i_instr_pc + i_imm);
`ifdef MISALIGN_TRAP_EN
      w_misalign = (w_target[1:0] != 2'b00);
      o_trap     = o_taken & w_misalign;
      o_next_pc  = i_pc_q;
      if (o_taken) begin
         o_next_pc = w_misalign ? TRAP_VEC : w_target;
      end
`else
      o_next_pc = o_taken ? word_align(w_target) : i_pc_q;
`endif
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Handshaked PC sequencer: one outstanding imem request, a one-entry decode buffer.
// Define MISALIGN_TRAP_EN to redirect misaligned branch/jump targets to TRAP_VEC.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
   ,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
`endif
) (
   input  logic         clk,
   input  logic         rst,
   fetch_ctrl_if.master bus
);

   fetch_state_t r_state;
   fetch_state_t w_next_state;

   logic [31:0] r_pc_q;
   logic        r_instr_valid;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;

   logic        w_consume;
   logic        w_taken;
   logic [31:0] w_next_pc;
   logic        w_imem_req;
   logic        w_accept;
   logic        w_capture;
`ifdef MISALIGN_TRAP_EN
   logic        w_trap;
`endif

   assign w_consume = r_instr_valid & bus.instr_ready;

   next_pc_sel #(
`ifdef MISALIGN_TRAP_EN
      .TRAP_VEC      (TRAP_VEC)
`endif
   ) u_next_pc_sel (
      .i_consume     (w_consume),
      .i_branch      (bus.branch),
      .i_zero_flag   (bus.zero_flag),
      .i_imm         (bus.imm),
      .i_jump        (bus.jump),
      .i_jump_target (bus.jump_target),
      .i_instr_pc    (r_instr_pc),
      .i_pc_q        (r_pc_q),
`ifdef MISALIGN_TRAP_EN
      .o_trap        (w_trap),
`endif
      .o_taken       (w_taken),
      .o_next_pc     (w_next_pc)
   );

   // A new request may share the cycle in which decode drains the buffer
   always_comb begin
      w_next_state = r_state;
      w_imem_req   = 1'b0;
      case (r_state)
         S_BOOT: begin
            w_next_state = S_REQ;
         end
         S_REQ: begin
            w_imem_req = ~r_instr_valid | w_consume;
            if (w_imem_req && bus.imem_ready) begin
               w_next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.imem_rvalid) begin
               w_next_state = S_REQ;
            end
         end
         default: begin
            w_next_state = S_BOOT;
         end
      endcase
   end

   assign w_accept  = w_imem_req & bus.imem_ready;
   assign w_capture = (r_state == S_WAIT) & bus.imem_rvalid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_BOOT;
      end else begin
         r_state <= w_next_state;
      end
   end

   // pc_q runs one word ahead of the outstanding fetch; a redirect without an accept parks the target
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc_q <= RESET_VEC;
      end else if (r_state == S_REQ) begin
         if (w_accept) begin
            r_pc_q <= w_next_pc + PC_STEP;
         end else if (w_taken) begin
            r_pc_q <= w_next_pc;
         end
      end
   end

   // Responses arriving outside S_WAIT (e.g. stale after reset) never reach the buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr_valid <= 1'b0;
         r_instr       <= NOP_INSTR;
         r_instr_pc    <= RESET_VEC;
      end else if (w_capture) begin
         r_instr_valid <= 1'b1;
         r_instr       <= bus.imem_rdata;
         r_instr_pc    <= r_pc_q - PC_STEP;
      end else if (w_consume) begin
         r_instr_valid <= 1'b0;
      end
   end

   assign bus.imem_req    = w_imem_req;
   assign bus.imem_addr   = w_next_pc;
   assign bus.instr_valid = r_instr_valid;
   assign bus.instr       = r_instr;
   assign bus.instr_pc    = r_instr_pc;
`ifdef MISALIGN_TRAP_EN
   assign bus.trap        = w_trap;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, branches, jumps, stalls, wrap and reset mid-fetch.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_ctrl_if bus();

   logic        memReady     = 1'b1;
   logic        memRvalid    = 1'b0;
   logic [31:0] memRdata     = 32'h0;
   logic        strayRvalid  = 1'b0;
   logic        instrReady   = 1'b0;
   logic        branchIn     = 1'b0;
   logic        zeroIn       = 1'b0;
   logic [31:0] immIn        = 32'h0;
   logic        jumpIn       = 1'b0;
   logic [31:0] jumpTargetIn = 32'h0;

   int errors = 0;
   int checks = 0;

   assign bus.imem_ready  = memReady;
   assign bus.imem_rvalid = memRvalid | strayRvalid;
   assign bus.imem_rdata  = memRdata;
   assign bus.instr_ready = instrReady;
   assign bus.branch      = branchIn;
   assign bus.zero_flag   = zeroIn;
   assign bus.imm         = immIn;
   assign bus.jump        = jumpIn;
   assign bus.jump_target = jumpTargetIn;

   fetch_ctrl #(
      .RESET_VEC (32'h0000_0000)
`ifdef MISALIGN_TRAP_EN
      ,
      .TRAP_VEC  (32'h0000_0100)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Memory answers exactly one cycle after each accept with a word tagged by its address
   always @(posedge clk) begin
      memRvalid <= bus.imem_req & memReady;
      memRdata  <= {16'hC0DE, bus.imem_addr[15:0]};
   end

   function automatic logic [31:0] expData(input logic [31:0] addr);
      return {16'hC0DE, addr[15:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rdy, input logic br, input logic zf,
                                input logic [31:0] im, input logic jp, input logic [31:0] tgt);
      instrReady   = rdy;
      branchIn     = br;
      zeroIn       = zf;
      immIn        = im;
      jumpIn       = jp;
      jumpTargetIn = tgt;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      strayRvalid = 1'b0;
      memReady    = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic waitValid(input string tag, input logic [31:0] expPc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.instr_valid !== 1'b1 && n < 20);
      checkOutput({tag, "_valid"}, {31'h0, bus.instr_valid}, 32'h1);
      checkOutput({tag, "_pc"}, bus.instr_pc, expPc);
      checkOutput({tag, "_instr"}, bus.instr, expData(expPc));
   endtask

   task automatic consume(input string tag, input logic br, input logic zf, input logic [31:0] im,
                          input logic jp, input logic [31:0] tgt, input logic [31:0] expAddr);
      applyStimulus(1'b1, br, zf, im, jp, tgt);
      #1;
      checkOutput({tag, "_req"}, {31'h0, bus.imem_req}, 32'h1);
      checkOutput({tag, "_addr"}, bus.imem_addr, expAddr);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] misTarget;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_req", {31'h0, bus.imem_req}, 32'h0);
      checkOutput("rst_addr", bus.imem_addr, 32'h0);
      checkOutput("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
      checkOutput("rst_instr", bus.instr, 32'h0000_0013);
      checkOutput("rst_pc", bus.instr_pc, 32'h0);
`ifdef MISALIGN_TRAP_EN
      checkOutput("rst_trap", {31'h0, bus.trap}, 32'h0);
`endif
      rst = 1'b0;

      // Boot cycle, accept, response, buffered
      @(negedge clk);
      checkOutput("boot_req", {31'h0, bus.imem_req}, 32'h1);
      checkOutput("boot_addr", bus.imem_addr, 32'h0);
      @(negedge clk);
      checkOutput("wait_req", {31'h0, bus.imem_req}, 32'h0);
      checkOutput("wait_valid", {31'h0, bus.instr_valid}, 32'h0);
      @(negedge clk);
      checkOutput("first_valid", {31'h0, bus.instr_valid}, 32'h1);
      checkOutput("first_pc", bus.instr_pc, 32'h0);
      checkOutput("first_instr", bus.instr, 32'hC0DE_0000);
      checkOutput("full_req", {31'h0, bus.imem_req}, 32'h0);

      consume("seq0", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
      waitValid("pc4", 32'h4);
      consume("seq4", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h8);
      waitValid("pc8", 32'h8);
      consume("brTaken", 1'b1, 1'b1, 32'd12, 1'b0, 32'h0, 32'd20);
      waitValid("pc20", 32'd20);

      doReset();
      waitValid("r_pc0", 32'h0);
      consume("r_seq0", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
      waitValid("r_pc4", 32'h4);
      consume("r_seq4", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h8);
      waitValid("r_pc8", 32'h8);
      consume("brNot", 1'b1, 1'b0, 32'd12, 1'b0, 32'h0, 32'd12);
      waitValid("pc12", 32'd12);

      // Decode stalls for 10 cycles; buffer must hold and no request goes out
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("stall_req", {31'h0, bus.imem_req}, 32'h0);
         checkOutput("stall_pc", bus.instr_pc, 32'd12);
         checkOutput("stall_instr", bus.instr, 32'hC0DE_000C);
      end
      consume("release", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'd16);
      waitValid("pc16", 32'd16);

      // Jump while memory is busy: target must be parked and reissued
      memReady = 1'b0;
      consume("jmp40", 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 32'h40);
      @(negedge clk);
      checkOutput("park_req", {31'h0, bus.imem_req}, 32'h1);
      checkOutput("park_addr", bus.imem_addr, 32'h40);
      checkOutput("park_valid", {31'h0, bus.instr_valid}, 32'h0);
      memReady = 1'b1;
      waitValid("pc40", 32'h40);

`ifdef MISALIGN_TRAP_EN
      misTarget = 32'h100;
`else
      misTarget = 32'h40;
`endif
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h42);
      #1;
      checkOutput("mis_req", {31'h0, bus.imem_req}, 32'h1);
      checkOutput("mis_addr", bus.imem_addr, misTarget);
`ifdef MISALIGN_TRAP_EN
      checkOutput("mis_trap", {31'h0, bus.trap}, 32'h1);
`endif
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef MISALIGN_TRAP_EN
      checkOutput("mis_trap_end", {31'h0, bus.trap}, 32'h0);
`endif
      waitValid("pcMis", misTarget);

      // PC wraps past the top of the address space
      consume("wrapJmp", 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
      waitValid("pcTop", 32'hFFFF_FFFC);
      consume("wrap", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      waitValid("pcWrap", 32'h0);

      // Reset while a fetch is outstanding; the late response must be dropped
      doReset();
      @(negedge clk);
      checkOutput("rw_req", {31'h0, bus.imem_req}, 32'h1);
      @(negedge clk);
      rst         = 1'b1;
      strayRvalid = 1'b1;
      #1;
      checkOutput("rw_rst_req", {31'h0, bus.imem_req}, 32'h0);
      checkOutput("rw_rst_addr", bus.imem_addr, 32'h0);
      checkOutput("rw_rst_valid", {31'h0, bus.instr_valid}, 32'h0);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      strayRvalid = 1'b0;
      @(negedge clk);
      checkOutput("stray_valid", {31'h0, bus.instr_valid}, 32'h0);
      checkOutput("stray_instr", bus.instr, 32'h0000_0013);
      checkOutput("restart_req", {31'h0, bus.imem_req}, 32'h1);
      checkOutput("restart_addr", bus.imem_addr, 32'h0);
      waitValid("restart", 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
